// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-block address decoder: response status codes
// and the access sequencer state encoding.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        StatusOkay         = 2'd0,
        StatusDecodeError  = 2'd1,
        StatusTimeout      = 2'd2,
        StatusCommandError = 2'd3
    } rggen_status_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAccess   = 2'd1,
        StResponse = 2'd2
    } rggen_state_e;

endpackage

// File: rtl/rggen_address_window_match.sv
// Combinational hit detector for one inclusive address window with an optional
// shadow index compare.
module rggen_address_window_match #(
    parameter int unsigned                  ADDRESS_WIDTH      = 16,
    parameter int unsigned                  SHADOW_INDEX_WIDTH = 1,
    parameter logic [ADDRESS_WIDTH-1:0]     START_ADDRESS      = '0,
    parameter logic [ADDRESS_WIDTH-1:0]     END_ADDRESS        = '0,
    parameter bit                           USE_SHADOW_INDEX   = 1'b0,
    parameter logic [SHADOW_INDEX_WIDTH-1:0] SHADOW_INDEX_VALUE = '0
) (
    input  logic [ADDRESS_WIDTH-1:0]      address,
    input  logic [SHADOW_INDEX_WIDTH-1:0] shadow_index,
    output logic                          match
);

    // Range test as an unsigned offset compare; windows are expected to have end >= start.
    localparam logic [ADDRESS_WIDTH-1:0] SPAN = END_ADDRESS - START_ADDRESS;

    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     address_hit;
    logic                     shadow_hit;

    always_comb begin
        offset = address - START_ADDRESS;
        if (START_ADDRESS == END_ADDRESS) begin
            address_hit = (address == START_ADDRESS);
        end else begin
            address_hit = (offset <= SPAN);
        end
        shadow_hit = !USE_SHADOW_INDEX || (shadow_index == SHADOW_INDEX_VALUE);
        match      = address_hit && shadow_hit;
    end

endmodule

// File: rtl/rggen_address_decoder_array.sv
// N-window registered decoder: captures one host request, drives a one-hot select
// until the entry acks, then returns a one-cycle OKAY/decode/timeout/command status.
module rggen_address_decoder_array
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned                              ADDRESS_WIDTH      = 16,
    parameter int unsigned                              REGISTERS          = 4,
    parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]       START_ADDRESS      = '0,
    parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]       END_ADDRESS        = '0,
    parameter logic [REGISTERS-1:0]                     USE_SHADOW_INDEX   = '0,
    parameter int unsigned                              SHADOW_INDEX_WIDTH = 1,
    parameter logic [REGISTERS*SHADOW_INDEX_WIDTH-1:0]  SHADOW_INDEX_VALUE = '0,
    parameter int unsigned                              TIMEOUT_CYCLES     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_read,
    input  logic                          i_write,
    input  logic [ADDRESS_WIDTH-1:0]      i_address,
    input  logic [SHADOW_INDEX_WIDTH-1:0] i_shadow_index,
    output logic [REGISTERS-1:0]          o_select,
    output logic                          o_write,
    input  logic [REGISTERS-1:0]          i_ack,
    output logic                          o_response_valid,
    output logic [1:0]                    o_status
);

    localparam int unsigned COUNT_WIDTH  =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [REGISTERS-1:0] hit_raw;
    logic [REGISTERS-1:0] hit_onehot;

    for (genvar i = 0; i < REGISTERS; i++) begin : g_window
        rggen_address_window_match #(
            .ADDRESS_WIDTH      (ADDRESS_WIDTH),
            .SHADOW_INDEX_WIDTH (SHADOW_INDEX_WIDTH),
            .START_ADDRESS      (START_ADDRESS[i*ADDRESS_WIDTH+:ADDRESS_WIDTH]),
            .END_ADDRESS        (END_ADDRESS[i*ADDRESS_WIDTH+:ADDRESS_WIDTH]),
            .USE_SHADOW_INDEX   (USE_SHADOW_INDEX[i]),
            .SHADOW_INDEX_VALUE (SHADOW_INDEX_VALUE[i*SHADOW_INDEX_WIDTH+:SHADOW_INDEX_WIDTH])
        ) u_match (
            .address      (i_address),
            .shadow_index (i_shadow_index),
            .match        (hit_raw[i])
        );
    end

    // Overlapping windows resolve to the lowest index.
    always_comb begin
        hit_onehot = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (hit_raw[i] && (hit_onehot == '0)) begin
                hit_onehot[i] = 1'b1;
            end
        end
    end

    rggen_state_e             state_q, state_d;
    rggen_status_e            status_q, status_d;
    logic [REGISTERS-1:0]     hit_q, hit_d;
    logic                     write_q, write_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        hit_d    = hit_q;
        write_d  = write_q;
        count_d  = count_q;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    write_d = i_write;
                    count_d = '0;
                    if (i_read == i_write) begin
                        hit_d    = '0;
                        status_d = StatusCommandError;
                        state_d  = StResponse;
                    end else begin
                        hit_d   = hit_onehot;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (hit_q == '0) begin
                    status_d = StatusDecodeError;
                    state_d  = StResponse;
                end else if ((i_ack & hit_q) != '0) begin
                    status_d = StatusOkay;
                    state_d  = StResponse;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (count_q == COUNT_WIDTH'(TIMEOUT_LAST))) begin
                    status_d = StatusTimeout;
                    state_d  = StResponse;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            StResponse: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            status_q <= StatusOkay;
            hit_q    <= '0;
            write_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            hit_q    <= hit_d;
            write_q  <= write_d;
            count_q  <= count_d;
        end
    end

    assign o_ready          = (state_q == StIdle);
    assign o_select         = (state_q == StAccess) ? hit_q : '0;
    assign o_write          = write_q;
    assign o_response_valid = (state_q == StResponse);
    assign o_status         = status_q;

endmodule

// File: tb/tb_rggen_address_decoder_array.sv
// Directed and random transactions checked against a window-table reference model.
module tb_rggen_address_decoder_array;

    localparam int AW = 16;
    localparam int NR = 4;
    localparam int SW = 2;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_read = 1'b0;
    logic          i_write = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [SW-1:0] i_shadow_index = '0;
    logic [NR-1:0] o_select;
    logic          o_write;
    logic [NR-1:0] i_ack = '0;
    logic          o_response_valid;
    logic [1:0]    o_status;

    int tests = 0;
    int errs  = 0;

    // Window table: w0 = 0x00 (shadow 2), w1 = 0x04, w2 = 0x04..0x0F (overlaps w1), w3 = 0x10.
    int win_start [NR] = '{'h00, 'h04, 'h04, 'h10};
    int win_end   [NR] = '{'h00, 'h04, 'h0F, 'h10};
    int win_shadow[NR] = '{2, -1, -1, -1};

    rggen_address_decoder_array #(
        .ADDRESS_WIDTH      (AW),
        .REGISTERS          (NR),
        .START_ADDRESS      ({16'h0010, 16'h0004, 16'h0004, 16'h0000}),
        .END_ADDRESS        ({16'h0010, 16'h000F, 16'h0004, 16'h0000}),
        .USE_SHADOW_INDEX   (4'b0001),
        .SHADOW_INDEX_WIDTH (SW),
        .SHADOW_INDEX_VALUE ({2'd0, 2'd0, 2'd0, 2'd2}),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_read           (i_read),
        .i_write          (i_write),
        .i_address        (i_address),
        .i_shadow_index   (i_shadow_index),
        .o_select         (o_select),
        .o_write          (o_write),
        .i_ack            (i_ack),
        .o_response_valid (o_response_valid),
        .o_status         (o_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_hit(input int addr, input int idx);
        for (int i = 0; i < NR; i++) begin
            if (addr >= win_start[i] && addr <= win_end[i] &&
                (win_shadow[i] < 0 || win_shadow[i] == idx)) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at cycle 0 (IDLE, #1 after an edge); returns at the first IDLE cycle after
    // the response. ack_cycle 0 means the selected entry never acks.
    task automatic txn(input string tag, input bit rd, input bit wr, input int addr,
                       input int idx, input int ack_cycle, input bit noisy);
        int         hit;
        logic [3:0] sel;
        int         resp;
        int         status;
        hit  = first_hit(addr, idx);
        sel  = (rd != wr && hit >= 0) ? 4'(1 << hit) : 4'b0000;
        if (rd == wr) begin
            resp = 1; status = 3;
        end else if (hit < 0) begin
            resp = 2; status = 1;
        end else if (ack_cycle >= 1 && ack_cycle <= TO) begin
            resp = ack_cycle + 1; status = 0;
        end else begin
            resp = TO + 1; status = 2;
        end
        check({tag, ".ready0"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_read = rd; i_write = wr;
        i_address = AW'(addr); i_shadow_index = SW'(idx);
        i_ack = '0;
        for (int c = 1; c <= resp; c++) begin
            tick();
            check({tag, ".select"}, 32'(o_select), (c < resp) ? 32'(sel) : 32'd0);
            check({tag, ".ready"}, 32'(o_ready), 32'd0);
            check({tag, ".rvalid"}, 32'(o_response_valid), (c == resp) ? 32'd1 : 32'd0);
            if (sel != 0 && c < resp) check({tag, ".write"}, 32'(o_write), 32'(wr));
            if (c == resp) check({tag, ".status"}, 32'(o_status), 32'(status));
            i_ack = 4'($urandom) & ~sel;
            if (sel != 0 && c == ack_cycle) i_ack = i_ack | sel;
            i_valid = noisy ? 1'($urandom) : 1'b0;
            i_read = 1'($urandom); i_write = 1'($urandom);
            i_address = AW'($urandom_range(0, 'h1F));
        end
        tick();
        check({tag, ".ready_after"}, 32'(o_ready), 32'd1);
        check({tag, ".rvalid_after"}, 32'(o_response_valid), 32'd0);
        i_valid = 1'b0; i_ack = '0;
    endtask

    initial begin
        tick();
        tick();
        check("reset.ready", 32'(o_ready), 32'd1);
        check("reset.select", 32'(o_select), 32'd0);
        check("reset.write", 32'(o_write), 32'd0);
        check("reset.rvalid", 32'(o_response_valid), 32'd0);
        check("reset.status", 32'(o_status), 32'd0);
        rst = 1'b0;
        tick();

        txn("read_0c", 1, 0, 'h0C, 0, 3, 0);
        txn("read_20", 1, 0, 'h20, 0, 1, 0);
        txn("shadow_idx1", 1, 0, 'h00, 1, 1, 0);
        txn("shadow_idx2", 1, 0, 'h00, 2, 1, 0);
        txn("overlap_04", 1, 0, 'h04, 0, 2, 0);
        txn("timeout", 1, 0, 'h10, 0, 0, 0);
        txn("ack_at_limit", 1, 0, 'h10, 0, TO, 0);
        txn("cmd_both", 1, 1, 'h0C, 0, 1, 0);
        txn("cmd_none", 0, 0, 'h0C, 0, 1, 0);
        txn("write_10", 0, 1, 'h10, 0, 2, 1);
        txn("write_timeout", 0, 1, 'h08, 0, 0, 0);

        // Reset during ACCESS: held status/write must clear and no response follows.
        i_valid = 1'b1; i_read = 1'b0; i_write = 1'b1; i_address = 'h0C;
        tick();
        i_valid = 1'b0;
        check("rst_mid.select_before", 32'(o_select), 32'b0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid.ready", 32'(o_ready), 32'd1);
        check("rst_mid.select", 32'(o_select), 32'd0);
        check("rst_mid.write", 32'(o_write), 32'd0);
        check("rst_mid.rvalid", 32'(o_response_valid), 32'd0);
        check("rst_mid.status", 32'(o_status), 32'd0);
        for (int i = 0; i < 3; i++) begin
            i_ack = 4'b0100;
            tick();
            check("rst_mid.no_resp", 32'(o_response_valid), 32'd0);
        end
        i_ack = '0;

        for (int n = 0; n < 60; n++) begin
            int a;
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 'hFFFF))
                                            : int'($urandom_range(0, 'h1F));
            txn("random", 1'($urandom), 1'($urandom), a, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
